// File: rtl/rvfi_regfile_check.sv
// rtl/rvfi_regfile_check.sv - RVFI register-file shadow and retire-order consistency checker
//
// Keeps a shadow copy of every architectural integer register. Checks each
// retired instruction's rs1/rs2 read data against it, enforces the x0
// invariants, and checks rvfi_order for gap-free sequencing across all retire
// channels. The first failure since reset is captured; err stays sticky.
//
// Optional feature macro: RVFI_REGFILE_CHECK_ASSERT_EN
//   defined   : an immediate assert fires in every cycle that has any failure
//   undefined : failures are reported only through the err outputs
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   rvfi_valid/trap    [NRET]        per-channel retire valid / trapped
//   rvfi_order         [NRET*ORDER_W] instruction index per channel
//   rvfi_rs1/rs2/rd_addr [NRET*5]    register addresses
//   rvfi_rs1/rs2_rdata, rvfi_rd_wdata [NRET*XLEN] register data
//   err                              sticky failure flag
//   err_kind/err_chan/err_order      kind, channel and order of first failure
module rvfi_regfile_check #(
    parameter int NRET      = 1,
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ORDER_W   = 64,
    parameter int ZERO_INIT = 0
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [NRET-1:0]                         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]                 rvfi_order,
    input  logic [NRET-1:0]                         rvfi_trap,
    input  logic [NRET*5-1:0]                       rvfi_rs1_addr,
    input  logic [NRET*5-1:0]                       rvfi_rs2_addr,
    input  logic [NRET*5-1:0]                       rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]                    rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0]                    rvfi_rs2_rdata,
    input  logic [NRET*XLEN-1:0]                    rvfi_rd_wdata,
    output logic                                    err,
    output logic [2:0]                              err_kind,
    output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] err_chan,
    output logic [ORDER_W-1:0]                      err_order
);

    localparam int          CW      = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int          AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0]  NREGS_L = 6'(NREGS);

    localparam logic [2:0] K_RS1   = 3'd1;
    localparam logic [2:0] K_RS2   = 3'd2;
    localparam logic [2:0] K_X0RD  = 3'd3;
    localparam logic [2:0] K_X0WR  = 3'd4;
    localparam logic [2:0] K_ORDER = 3'd5;
    localparam logic [2:0] K_ADDR  = 3'd6;

    // Architectural state, shadow flattened as NREGS words of XLEN bits
    logic [NREGS*XLEN-1:0] r_shadow;
    logic [NREGS-1:0]      r_written;
    logic [ORDER_W-1:0]    r_next_order;
    logic                  r_order_seen;

    logic                  r_err;
    logic [2:0]            r_err_kind;
    logic [CW-1:0]         r_err_chan;
    logic [ORDER_W-1:0]    r_err_order;

    // Forwarding chain: state as seen after the last processed channel
    logic [NREGS*XLEN-1:0] w_shadow;
    logic [NREGS-1:0]      w_written;
    logic [ORDER_W-1:0]    w_next_order;
    logic                  w_order_seen;

    // First failing channel this cycle
    logic                  w_fail;
    logic [2:0]            w_fail_kind;
    logic [CW-1:0]         w_fail_chan;
    logic [ORDER_W-1:0]    w_fail_order;

    // Per-channel working values
    logic [ORDER_W-1:0]    w_ord;
    logic [4:0]            w_rs1_a, w_rs2_a, w_rd_a;
    logic [XLEN-1:0]       w_rs1_d, w_rs2_d, w_rd_d;
    logic [AW-1:0]         w_rs1_i, w_rs2_i, w_rd_i;
    logic                  w_rs1_in, w_rs2_in, w_rd_in;
    logic                  w_oob, w_x0r, w_x0w, w_m1, w_m2, w_gap;
    logic [2:0]            w_kind;

    always_comb begin
        w_shadow     = r_shadow;
        w_written    = r_written;
        w_next_order = r_next_order;
        w_order_seen = r_order_seen;
        w_fail       = 1'b0;
        w_fail_kind  = 3'd0;
        w_fail_chan  = '0;
        w_fail_order = '0;
        w_ord        = '0;
        w_rs1_a = '0; w_rs2_a = '0; w_rd_a = '0;
        w_rs1_d = '0; w_rs2_d = '0; w_rd_d = '0;
        w_rs1_i = '0; w_rs2_i = '0; w_rd_i = '0;
        w_rs1_in = 1'b0; w_rs2_in = 1'b0; w_rd_in = 1'b0;
        w_oob = 1'b0; w_x0r = 1'b0; w_x0w = 1'b0;
        w_m1 = 1'b0; w_m2 = 1'b0; w_gap = 1'b0;
        w_kind = 3'd0;

        for (int c = 0; c < NRET; c++) begin
            w_ord    = rvfi_order[c*ORDER_W +: ORDER_W];
            w_rs1_a  = rvfi_rs1_addr[c*5 +: 5];
            w_rs2_a  = rvfi_rs2_addr[c*5 +: 5];
            w_rd_a   = rvfi_rd_addr[c*5 +: 5];
            w_rs1_d  = rvfi_rs1_rdata[c*XLEN +: XLEN];
            w_rs2_d  = rvfi_rs2_rdata[c*XLEN +: XLEN];
            w_rd_d   = rvfi_rd_wdata[c*XLEN +: XLEN];
            w_rs1_i  = w_rs1_a[AW-1:0];
            w_rs2_i  = w_rs2_a[AW-1:0];
            w_rd_i   = w_rd_a[AW-1:0];
            w_rs1_in = ({1'b0, w_rs1_a} < NREGS_L);
            w_rs2_in = ({1'b0, w_rs2_a} < NREGS_L);
            w_rd_in  = ({1'b0, w_rd_a} < NREGS_L);
            w_oob = 1'b0; w_x0r = 1'b0; w_x0w = 1'b0;
            w_m1 = 1'b0; w_m2 = 1'b0; w_gap = 1'b0;
            w_kind = 3'd0;

            if (rvfi_valid[c]) begin
                if (!rvfi_trap[c]) begin
                    w_oob = !w_rs1_in || !w_rs2_in || !w_rd_in;
                    w_x0r = ((w_rs1_a == 5'd0) && (w_rs1_d != '0)) ||
                            ((w_rs2_a == 5'd0) && (w_rs2_d != '0));
                    w_x0w = (w_rd_a == 5'd0) && (w_rd_d != '0);
                    // Reads see the state before this channel's own write
                    w_m1  = w_rs1_in && (w_rs1_a != 5'd0) && w_written[w_rs1_i] &&
                            (w_rs1_d != w_shadow[int'(w_rs1_i)*XLEN +: XLEN]);
                    w_m2  = w_rs2_in && (w_rs2_a != 5'd0) && w_written[w_rs2_i] &&
                            (w_rs2_d != w_shadow[int'(w_rs2_i)*XLEN +: XLEN]);
                end
                w_gap = w_order_seen && (w_ord != w_next_order);

                if (w_oob)      w_kind = K_ADDR;
                else if (w_x0r) w_kind = K_X0RD;
                else if (w_x0w) w_kind = K_X0WR;
                else if (w_m1)  w_kind = K_RS1;
                else if (w_m2)  w_kind = K_RS2;
                else if (w_gap) w_kind = K_ORDER;

                w_order_seen = 1'b1;
                w_next_order = w_ord + ORDER_W'(1);

                if (!rvfi_trap[c] && w_rd_in && (w_rd_a != 5'd0)) begin
                    w_shadow[int'(w_rd_i)*XLEN +: XLEN] = w_rd_d;
                    w_written[w_rd_i]                   = 1'b1;
                end

                if ((w_kind != 3'd0) && !w_fail) begin
                    w_fail       = 1'b1;
                    w_fail_kind  = w_kind;
                    w_fail_chan  = CW'(c);
                    w_fail_order = w_ord;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shadow     <= '0;
            r_written    <= {NREGS{ZERO_INIT != 0}};
            r_next_order <= '0;
            r_order_seen <= 1'b0;
            r_err        <= 1'b0;
            r_err_kind   <= 3'd0;
            r_err_chan   <= '0;
            r_err_order  <= '0;
        end else begin
            r_shadow     <= w_shadow;
            r_written    <= w_written;
            r_next_order <= w_next_order;
            r_order_seen <= w_order_seen;
            if (w_fail) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_kind  <= w_fail_kind;
                    r_err_chan  <= w_fail_chan;
                    r_err_order <= w_fail_order;
                end
            end
        end
    end

`ifdef RVFI_REGFILE_CHECK_ASSERT_EN
    always_ff @(posedge clk) begin
        if (resetn) begin
            a_no_fail: assert (!w_fail);
        end
    end
`endif

    assign err       = r_err;
    assign err_kind  = r_err_kind;
    assign err_chan  = r_err_chan;
    assign err_order = r_err_order;

endmodule

// File: tb/tb_rvfi_regfile_check.sv
// tb/tb_rvfi_regfile_check.sv - directed self-checking bench for rvfi_regfile_check
module tb_rvfi_regfile_check;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Single-channel stimulus shared by dut_a (defaults) and dut_z (ZERO_INIT=1, NREGS=16)
    logic        s_valid = 1'b0;
    logic [63:0] s_order = '0;
    logic        s_trap  = 1'b0;
    logic [4:0]  s_rs1a = '0, s_rs2a = '0, s_rda = '0;
    logic [31:0] s_rs1d = '0, s_rs2d = '0, s_rdd = '0;

    logic        a_err, z_err;
    logic [2:0]  a_kind, z_kind;
    logic [0:0]  a_chan, z_chan;
    logic [63:0] a_order, z_order;

    // Two-channel stimulus for dut_b
    logic [1:0]   d_valid = '0;
    logic [127:0] d_order = '0;
    logic [1:0]   d_trap  = '0;
    logic [9:0]   d_rs1a = '0, d_rs2a = '0, d_rda = '0;
    logic [63:0]  d_rs1d = '0, d_rs2d = '0, d_rdd = '0;

    logic        b_err;
    logic [2:0]  b_kind;
    logic [0:0]  b_chan;
    logic [63:0] b_order;

    rvfi_regfile_check #(.NRET(1), .XLEN(32), .NREGS(32), .ORDER_W(64), .ZERO_INIT(0)) dut_a (
        .clk(clk), .resetn(resetn), .rvfi_valid(s_valid), .rvfi_order(s_order), .rvfi_trap(s_trap),
        .rvfi_rs1_addr(s_rs1a), .rvfi_rs2_addr(s_rs2a), .rvfi_rd_addr(s_rda),
        .rvfi_rs1_rdata(s_rs1d), .rvfi_rs2_rdata(s_rs2d), .rvfi_rd_wdata(s_rdd),
        .err(a_err), .err_kind(a_kind), .err_chan(a_chan), .err_order(a_order));

    rvfi_regfile_check #(.NRET(1), .XLEN(32), .NREGS(16), .ORDER_W(64), .ZERO_INIT(1)) dut_z (
        .clk(clk), .resetn(resetn), .rvfi_valid(s_valid), .rvfi_order(s_order), .rvfi_trap(s_trap),
        .rvfi_rs1_addr(s_rs1a), .rvfi_rs2_addr(s_rs2a), .rvfi_rd_addr(s_rda),
        .rvfi_rs1_rdata(s_rs1d), .rvfi_rs2_rdata(s_rs2d), .rvfi_rd_wdata(s_rdd),
        .err(z_err), .err_kind(z_kind), .err_chan(z_chan), .err_order(z_order));

    rvfi_regfile_check #(.NRET(2), .XLEN(32), .NREGS(32), .ORDER_W(64), .ZERO_INIT(0)) dut_b (
        .clk(clk), .resetn(resetn), .rvfi_valid(d_valid), .rvfi_order(d_order), .rvfi_trap(d_trap),
        .rvfi_rs1_addr(d_rs1a), .rvfi_rs2_addr(d_rs2a), .rvfi_rd_addr(d_rda),
        .rvfi_rs1_rdata(d_rs1d), .rvfi_rs2_rdata(d_rs2d), .rvfi_rd_wdata(d_rdd),
        .err(b_err), .err_kind(b_kind), .err_chan(b_chan), .err_order(b_order));

    task automatic tick();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        d_valid = '0;
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        s_valid = 1'b0;
        d_valid = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic set1(input logic [63:0] ord, input logic trap,
                        input logic [4:0] rs1a, input logic [31:0] rs1d,
                        input logic [4:0] rs2a, input logic [31:0] rs2d,
                        input logic [4:0] rda, input logic [31:0] rdd);
        s_valid = 1'b1; s_order = ord; s_trap = trap;
        s_rs1a = rs1a; s_rs1d = rs1d; s_rs2a = rs2a; s_rs2d = rs2d;
        s_rda = rda; s_rdd = rdd;
    endtask

    task automatic ret1(input logic [63:0] ord, input logic trap,
                        input logic [4:0] rs1a, input logic [31:0] rs1d,
                        input logic [4:0] rs2a, input logic [31:0] rs2d,
                        input logic [4:0] rda, input logic [31:0] rdd);
        set1(ord, trap, rs1a, rs1d, rs2a, rs2d, rda, rdd);
        tick();
    endtask

    task automatic set2(input int c, input logic [63:0] ord,
                        input logic [4:0] rs1a, input logic [31:0] rs1d,
                        input logic [4:0] rs2a, input logic [31:0] rs2d,
                        input logic [4:0] rda, input logic [31:0] rdd);
        d_valid[c] = 1'b1; d_trap[c] = 1'b0;
        d_order[c*64 +: 64] = ord;
        d_rs1a[c*5 +: 5] = rs1a; d_rs1d[c*32 +: 32] = rs1d;
        d_rs2a[c*5 +: 5] = rs2a; d_rs2d[c*32 +: 32] = rs2d;
        d_rda[c*5 +: 5]  = rda;  d_rdd[c*32 +: 32]  = rdd;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", a_err); end
        checks++; if (a_kind !== 3'd0) begin errors++; $display("FAIL reset_kind got=%0d exp=0", a_kind); end
        checks++; if (a_chan !== 1'b0) begin errors++; $display("FAIL reset_chan got=%0d exp=0", a_chan); end
        checks++; if (a_order !== 64'd0) begin errors++; $display("FAIL reset_order got=%0h exp=0", a_order); end
        checks++; if (b_err !== 1'b0 || z_err !== 1'b0) begin errors++; $display("FAIL reset_err_bz got=%0h/%0h exp=0/0", b_err, z_err); end
    endtask

    task automatic test_rs1_shadow();
        do_reset();
        ret1(64'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h1234);
        ret1(64'd1, 1'b0, 5'd5, 32'h1234, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rs1_match err got=%0h exp=0", a_err); end
        do_reset();
        ret1(64'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h1234);
        set1(64'd1, 1'b0, 5'd5, 32'h1235, 5'd0, 32'd0, 5'd0, 32'd0);
        #1;
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rs1_latency err got=%0h exp=0 before edge", a_err); end
        tick();
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL rs1_mismatch err got=%0h exp=1", a_err); end
        checks++; if (a_kind !== 3'd1) begin errors++; $display("FAIL rs1_mismatch kind got=%0d exp=1", a_kind); end
        checks++; if (a_order !== 64'd1) begin errors++; $display("FAIL rs1_mismatch order got=%0h exp=1", a_order); end
        // rs1 mismatch outranks an order gap on the same retire
        do_reset();
        ret1(64'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'd1);
        ret1(64'd7, 1'b0, 5'd5, 32'd2, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (a_kind !== 3'd1) begin errors++; $display("FAIL rs1_over_gap kind got=%0d exp=1", a_kind); end
    endtask

    task automatic test_order();
        do_reset();
        ret1(64'd3, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        ret1(64'd5, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (a_kind !== 3'd5) begin errors++; $display("FAIL order_gap kind got=%0d exp=5", a_kind); end
        checks++; if (a_order !== 64'd5) begin errors++; $display("FAIL order_gap order got=%0h exp=5", a_order); end
        do_reset();
        ret1(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        ret1(64'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        ret1(64'd1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL order_wrap err got=%0h exp=0", a_err); end
    endtask

    task automatic test_x0();
        do_reset();
        ret1(64'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd1);
        checks++; if (a_kind !== 3'd4) begin errors++; $display("FAIL x0_write kind got=%0d exp=4", a_kind); end
        do_reset();
        ret1(64'd0, 1'b0, 5'd0, 32'd9, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (a_kind !== 3'd3) begin errors++; $display("FAIL x0_read kind got=%0d exp=3", a_kind); end
        do_reset();
        ret1(64'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'd77, 5'd0, 32'd55);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL trap_ignored err got=%0h exp=0", a_err); end
    endtask

    task automatic test_zero_init_nregs16();
        do_reset();
        ret1(64'd0, 1'b0, 5'd12, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (z_err !== 1'b0) begin errors++; $display("FAIL zinit_read0 err got=%0h exp=0", z_err); end
        ret1(64'd1, 1'b0, 5'd12, 32'd4, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (z_kind !== 3'd1) begin errors++; $display("FAIL zinit_read4 kind got=%0d exp=1", z_kind); end
        checks++; if (z_order !== 64'd1) begin errors++; $display("FAIL zinit_read4 order got=%0h exp=1", z_order); end
        do_reset();
        ret1(64'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd20, 32'd3);
        checks++; if (z_kind !== 3'd6) begin errors++; $display("FAIL nregs16_rd20 kind got=%0d exp=6", z_kind); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL nregs32_rd20 err got=%0h exp=0", a_err); end
        do_reset();
        ret1(64'd0, 1'b0, 5'd0, 32'd9, 5'd0, 32'd0, 5'd20, 32'd3);
        checks++; if (z_kind !== 3'd6) begin errors++; $display("FAIL addr_over_x0 kind got=%0d exp=6", z_kind); end
        checks++; if (a_kind !== 3'd3) begin errors++; $display("FAIL x0_only kind got=%0d exp=3", a_kind); end
    endtask

    task automatic test_two_channel();
        do_reset();
        set2(0, 64'd10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 32'hAA);
        set2(1, 64'd11, 5'd0, 32'd0, 5'd7, 32'hAA, 5'd0, 32'd0);
        tick();
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL fwd_match err got=%0h exp=0", b_err); end
        do_reset();
        set2(0, 64'd10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 32'hAA);
        set2(1, 64'd11, 5'd0, 32'd0, 5'd7, 32'hAB, 5'd0, 32'd0);
        tick();
        checks++; if (b_kind !== 3'd2) begin errors++; $display("FAIL fwd_mismatch kind got=%0d exp=2", b_kind); end
        checks++; if (b_chan !== 1'b1) begin errors++; $display("FAIL fwd_mismatch chan got=%0d exp=1", b_chan); end
        checks++; if (b_order !== 64'd11) begin errors++; $display("FAIL fwd_mismatch order got=%0h exp=11", b_order); end
        do_reset();
        set2(0, 64'd20, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd1);
        set2(1, 64'd21, 5'd0, 32'd1, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        checks++; if (b_kind !== 3'd4 || b_chan !== 1'b0) begin errors++; $display("FAIL lowest_chan kind/chan got=%0d/%0d exp=4/0", b_kind, b_chan); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set2(1, 64'd30, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'h55);
        d_order[63:0] = 64'd99;
        tick();
        set2(0, 64'd31, 5'd9, 32'h55, 5'd0, 32'd0, 5'd0, 32'd0);
        set2(1, 64'd32, 5'd0, 32'd0, 5'd9, 32'h55, 5'd0, 32'd0);
        tick();
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL skip_and_next_cycle err got=%0h exp=0", b_err); end
        set2(0, 64'd33, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        set2(1, 64'd35, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        checks++; if (b_kind !== 3'd5 || b_chan !== 1'b1 || b_order !== 64'd35) begin
            errors++; $display("FAIL chan_gap kind/chan/order got=%0d/%0d/%0d exp=5/1/35", b_kind, b_chan, b_order); end
    endtask

    task automatic test_first_capture();
        do_reset();
        ret1(64'd4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd1);
        ret1(64'd6, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL sticky err got=%0h exp=1", a_err); end
        checks++; if (a_kind !== 3'd4 || a_order !== 64'd4) begin errors++; $display("FAIL first_capture kind/order got=%0d/%0d exp=4/4", a_kind, a_order); end
        do_reset();
        checks++; if (a_err !== 1'b0 || a_kind !== 3'd0 || a_chan !== 1'b0 || a_order !== 64'd0) begin
            errors++; $display("FAIL midreset outputs got=%0h/%0d/%0d/%0h exp=0/0/0/0", a_err, a_kind, a_chan, a_order); end
        ret1(64'd100, 1'b0, 5'd5, 32'h1234_5678, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL post_reset_order100 err got=%0h exp=0", a_err); end
    endtask

    initial begin
        test_reset();
        test_rs1_shadow();
        test_order();
        test_x0();
        test_zero_init_nregs16();
        test_two_channel();
        test_back_to_back();
        test_first_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
